// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the nibble-serial add/subtract controller.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIB_W = 4;

    // Width of the nibble step counter; never narrower than one bit.
    function automatic int cnt_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/addsub_serial_ctrl_slice.sv
// Shared 4-bit adder slice: plain a + b + cin; operand inversion belongs to the caller.
module nibble_add_slice
    import addsub_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    input  logic             cin_i,
    output logic [NIB_W-1:0] s_o,
    output logic             cout_o
);

    logic [NIB_W:0] sum_s;

    assign sum_s  = {1'b0, a_i} + {1'b0, b_i} + {{NIB_W{1'b0}}, cin_i};
    assign s_o    = sum_s[NIB_W-1:0];
    assign cout_o = sum_s[NIB_W];

endmodule

// File: rtl/addsub_serial_ctrl.sv
// WIDTH-bit add/subtract sequenced over one 4-bit slice, LSB nibble first,
// with valid/ready handshakes on operation start and result delivery.
module addsub_serial_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] res,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int CNT_W = cnt_width(NIB);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [NIB_W-1:0] a_nib_s, b_nib_s, sum_nib_s;
    logic             slice_cout_s;

    assign a_nib_s = a_q[NIB_W*cnt_q +: NIB_W];
    assign b_nib_s = b_q[NIB_W*cnt_q +: NIB_W] ^ {NIB_W{sub_q}};

    nibble_add_slice u_slice (
        .a_i    (a_nib_s),
        .b_i    (b_nib_s),
        .cin_i  (carry_q),
        .s_o    (sum_nib_s),
        .cout_o (slice_cout_s)
    );

    // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    sub_d   = sub;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d[NIB_W*cnt_q +: NIB_W] = sum_nib_s;
                carry_d = slice_cout_s;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Final nibble bypasses acc so res is published whole in one edge.
                    res_d   = {sum_nib_s, acc_q[WIDTH-NIB_W-1:0]};
                    cout_d  = slice_cout_s;
                    ovf_d   = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q)) &&
                              (sum_nib_s[NIB_W-1] != a_q[WIDTH-1]);
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (done_ready) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done_valid  = done_q;
    assign res         = res_q;
    assign carry_out   = cout_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed results, a monitor pops on each result handshake.
module tb_addsub_serial_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [15:0] op_a = 16'h0000;
    logic [15:0] op_b = 16'h0000;
    logic        sub = 1'b0;
    logic        busy;
    logic        done_valid;
    logic        done_ready = 1'b1;
    logic [15:0] res;
    logic        carry_out;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] r;
        logic        c;
        logic        o;
    } exp_t;
    exp_t exp_q[$];

    addsub_serial_ctrl #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .sub         (sub),
        .busy        (busy),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .res         (res),
        .carry_out   (carry_out),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    // Monitor: compare every accepted result against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done_valid && done_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(res), 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    check("res", 32'(res), 32'(e.r));
                    check("carry_out", 32'(carry_out), 32'(e.c));
                    check("overflow", 32'(overflow), 32'(e.o));
                end
            end
        end
    end

    // Drive one operation, wait for accept, then count cycles to done_valid.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input bit expect_res, input logic [15:0] r, input logic c,
                         input logic o, input bit scramble);
        exp_t e;
        int n;
        int cyc;
        if (expect_res) begin
            e.r = r; e.c = c; e.o = o;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        op_a = a; op_b = b; sub = s; start_valid = 1'b1;
        n = 0;
        while (!start_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!start_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            start_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
        if (!expect_res) return;
        cyc = 0;
        while (cyc < 20) begin
            if (scramble) begin
                op_a = 16'($urandom); op_b = 16'($urandom); sub = ~sub;
            end
            @(posedge clk); #1;
            cyc++;
            if (done_valid) break;
        end
        check("latency", 32'(cyc), 32'd4);
    endtask

    task automatic handshake();
        done_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #12;
        // Reset state
        check("rst_res", 32'(res), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_flags", {30'd0, carry_out, overflow}, 32'd0);
        #3 rst_n = 1'b1;
        #2 check("rst_start_ready", 32'(start_ready), 32'd1);

        // Basic add, ripple, overflow
        issue(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0); handshake();
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0); handshake();
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0); handshake();

        // Subtract with borrow and overflow
        issue(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0); handshake();
        issue(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0); handshake();

        // Backpressure with start pulses that must be ignored
        done_ready = 1'b0;
        issue(16'h1111, 16'h2222, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            op_a = 16'hAAAA; op_b = 16'h5555; sub = 1'b1;
            start_valid = (i % 2 == 0);
            @(posedge clk); #1;
            check("bp_res", 32'(res), 32'h3333);
            check("bp_flags", {30'd0, carry_out, overflow}, 32'd0);
            check("bp_start_ready", 32'(start_ready), 32'd0);
            check("bp_done_valid", 32'(done_valid), 32'd1);
        end
        start_valid = 1'b0;
        handshake();
        check("bp_idle_after", 32'(start_ready), 32'd1);
        check("bp_res_held", 32'(res), 32'h3333);

        // Back-to-back with start_valid held high
        exp_q.push_back('{r: 16'h1000, c: 1'b0, o: 1'b0});
        exp_q.push_back('{r: 16'h00FF, c: 1'b1, o: 1'b0});
        op_a = 16'h00FF; op_b = 16'h0F01; sub = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        op_a = 16'h0100; op_b = 16'h0001; sub = 1'b1;
        n = 0;
        while (!done_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("b2b_first_done", 32'(done_valid), 32'd1);
        @(posedge clk); #1;
        check("b2b_no_same_cycle_accept", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("b2b_second_accept", 32'(busy), 32'd1);
        start_valid = 1'b0;
        n = 0;
        while (!done_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("b2b_second_done", 32'(done_valid), 32'd1);
        handshake();

        // Reset in the middle of RUN
        issue(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_done_valid", 32'(done_valid), 32'd0);
        check("mid_rst_res", 32'(res), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0); handshake();

        // Operand ports scrambled during RUN
        issue(16'h0A0B, 16'h0102, 1'b0, 1'b1, 16'h0B0D, 1'b0, 1'b0, 1'b1); handshake();
        issue(16'h9000, 16'h2000, 1'b1, 1'b1, 16'h7000, 1'b1, 1'b1, 1'b1); handshake();

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_serial_ctrl.md
Name: addsub_serial_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by reusing one 4-bit adder slice, one nibble per cycle, LSB nibble first. The carry is held in a register between nibbles. Operands are accepted on a valid/ready start handshake and results are returned on a valid/ready done handshake. It sits between a requesting unit and the shared 4-bit add/sub resource, giving wide arithmetic at nibble-datapath cost.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
NIB, WIDTH/4, derived localparam giving the number of nibble steps; not overridable.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  requester presents an operation
start_ready  out  1  controller can accept an operation
op_a  in  WIDTH  operand A, sampled on start handshake
op_b  in  WIDTH  operand B, sampled on start handshake
sub  in  1  0 = A+B, 1 = A-B; sampled on start handshake
busy  out  1  high in RUN or DONE
done_valid  out  1  result available
done_ready  in  1  consumer accepts result
res  out  WIDTH  result
carry_out  out  1  final carry; for subtract, 1 = no borrow
overflow  out  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset:
  - state=IDLE; start_ready=1 after release.
  - busy, done_valid, res, carry_out and overflow all 0.
  - Nibble counter, carry register and operand registers all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid & start_ready: capture op_a, op_b and sub; set carry_reg=sub; set cnt=0; go to RUN.
- RUN (start_ready=0, busy=1), each cycle:
  - a_n = A[4*cnt+:4]; b_n = B[4*cnt+:4] ^ {4{sub}}.
  - {c,s} = a_n + b_n + carry_reg, computed 5 bits wide.
  - Write s into acc[4*cnt+:4]; set carry_reg=c; cnt++.
  - When cnt==NIB-1, go to DONE next edge.
- Entering DONE:
  - res = full accumulated result; carry_out = final carry.
  - overflow = (A[MSB] == b_eff[MSB]) & (res[MSB] != A[MSB]), where b_eff = B ^ {WIDTH{sub}}.
  - done_valid=1.
- Latency: accept at edge T → done_valid high after edge T+NIB (4 cycles for WIDTH=16). The cycle count is fixed and independent of data.
- DONE:
  - res, carry_out, overflow and done_valid hold stable until done_ready=1.
  - On done_valid & done_ready: done_valid=0 and go to IDLE.
  - start_ready rises the following cycle; no accept occurs in the same cycle as completion.
- res, carry_out and overflow keep their last value after handshake until the next completion. res is never updated nibble-by-nibble at the port.
- start_valid while busy: ignored, no capture. Operand port changes during RUN have no effect.
- done_ready while not done_valid: ignored.
- Reset mid-RUN or mid-DONE: the operation is aborted and all outputs return to reset values immediately. No partial result is ever flagged valid.
- Carry wrap: a carry out of the MSB nibble goes to carry_out only; it is never fed back.

Decomposition:
- Package addsub_pkg holds:
  - state enum {IDLE, RUN, DONE} (2-bit encoding);
  - localparam NIB_W = 4;
  - the function for nibble count width.
- Sub-module nibble_add_slice (combinational): 4-bit a, 4-bit b, cin → 4-bit s, cout. It is the shared slice; the controller owns B inversion and carry seeding.
- Counter width is $clog2(NIB).

Test Plan:
1. Basic add, carry ripple, overflow:
   - Add 0x1234 + 0x4321 → res=0x5555, carry_out=0, overflow=0; done_valid exactly 4 cycles after accept.
   - Add 0xFFFF + 0x0001 → res=0x0000, carry_out=1, overflow=0; the carry ripples through all 4 nibbles.
   - Add 0x7FFF + 0x0001 → res=0x8000, carry_out=0, overflow=1.
2. Subtract with borrow and overflow:
   - Sub 0x0005 − 0x0007 → res=0xFFFE, carry_out=0 (borrow), overflow=0.
   - Sub 0x8000 − 0x0001 → res=0x7FFF, carry_out=1, overflow=1.
3. Backpressure: hold done_ready=0 for 5 cycles after done_valid, and pulse start_valid during that time.
   - res, carry_out and overflow stay stable; start_ready=0; the pulses are not captured.
   - Raise done_ready → IDLE next cycle.
4. Back-to-back operations: hold start_valid high with new operands (0x00FF + 0x0F01, then sub 0x0100 − 0x0001).
   - Results are 0x1000 and 0x00FF respectively.
   - The second accept occurs one cycle after the first completion handshake.
5. Reset mid-operation: assert rst_n=0 after 2 RUN cycles.
   - done_valid, res and busy go to 0 immediately; state=IDLE.
   - After release, add 0x0001 + 0x0001 → 0x0002 with correct latency.
6. Operand change during RUN: modify op_a/op_b/sub on every RUN cycle.
   - The result matches the operands captured at accept only.
